// File: rtl/serializador_if.sv
// Byte-in / bit-out bus of the serial link transmitter.
// Master is the byte source and serial sink side; slave is the transmitter.
interface serializador_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       hold_in;
    logic       data_out;
    logic       write_out;
    logic       done_out;
    logic       status_out;

    modport master (
        output data_in, valid_in, hold_in,
        input  ready_out, data_out, write_out, done_out, status_out
    );

    modport slave (
        input  data_in, valid_in, hold_in,
        output ready_out, data_out, write_out, done_out, status_out
    );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: one-byte holding buffer feeding an MSB-first
// shifter, one write_out strobe per bit, GAP_CYCLES idle cycles after each strobe.
module serializador #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic          clock,
    input logic          reset,
    serializador_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam bit         NO_GAP = (GAP_CYCLES == 0);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

    state_t     state_q;
    logic [7:0] buf_q;
    logic       buf_vld_q;
    logic [7:0] sh_q;
    logic [2:0] bit_q;
    logic [3:0] gap_q;
    logic       dout_q;
    logic       wr_q;
    logic       done_q;

    logic accept;
    logic bit_end;
    logic byte_end;
    logic start;

    // bit_end marks the edge that closes one bit slot (strobe plus its gap).
    always_comb begin
        accept   = bus.valid_in && !buf_vld_q;
        bit_end  = (state_q == SEND && NO_GAP) || (state_q == GAP && gap_q == 4'd1);
        byte_end = bit_end && (bit_q == 3'd7);
        start    = (state_q == IDLE || byte_end) && buf_vld_q && !bus.hold_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            buf_q     <= 8'd0;
            buf_vld_q <= 1'b0;
            sh_q      <= 8'd0;
            bit_q     <= 3'd0;
            gap_q     <= 4'd0;
            dout_q    <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= byte_end;

            if (accept) begin
                buf_q     <= bus.data_in;
                buf_vld_q <= 1'b1;
            end

            // A byte start also covers back-to-back chaining at a byte end.
            if (start) begin
                sh_q      <= buf_q;
                buf_vld_q <= 1'b0;
                bit_q     <= 3'd0;
                dout_q    <= buf_q[7];
                wr_q      <= 1'b1;
                state_q   <= SEND;
            end else if (byte_end) begin
                state_q <= IDLE;
            end else if (bit_end) begin
                sh_q    <= {sh_q[6:0], 1'b0};
                bit_q   <= bit_q + 3'd1;
                dout_q  <= sh_q[6];
                wr_q    <= 1'b1;
                state_q <= SEND;
            end else if (state_q == SEND) begin
                gap_q   <= GAP_LD;
                state_q <= GAP;
            end else if (state_q == GAP) begin
                gap_q <= gap_q - 4'd1;
            end
        end
    end

    assign bus.ready_out  = !buf_vld_q;
    assign bus.status_out = (state_q != IDLE) || buf_vld_q;
    assign bus.data_out   = dout_q;
    assign bus.write_out  = wr_q;
    assign bus.done_out   = done_q;
endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: two instances (GAP_CYCLES=1 and 0) checked every cycle
// against a slot-timeline model, plus directed literal checks on received bytes.
module tb_serializador;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0] din [2];
    logic       vin [2];
    logic       hin [2];

    serializador_if if0();
    serializador_if if1();

    assign if0.data_in  = din[0];
    assign if0.valid_in = vin[0];
    assign if0.hold_in  = hin[0];
    assign if1.data_in  = din[1];
    assign if1.valid_in = vin[1];
    assign if1.hold_in  = hin[1];

    serializador #(.GAP_CYCLES(1)) u0 (.clock(clock), .reset(reset), .bus(if0.slave));
    serializador #(.GAP_CYCLES(0)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));

    logic w_o [2], d_o [2], dn_o [2], r_o [2], s_o [2];
    assign w_o[0] = if0.write_out;  assign w_o[1] = if1.write_out;
    assign d_o[0] = if0.data_out;   assign d_o[1] = if1.data_out;
    assign dn_o[0] = if0.done_out;  assign dn_o[1] = if1.done_out;
    assign r_o[0] = if0.ready_out;  assign r_o[1] = if1.ready_out;
    assign s_o[0] = if0.status_out; assign s_o[1] = if1.status_out;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(string nm, int i, logic [15:0] a, logic [15:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[u%0d] got %0h expected %0h (cycle %0d)", nm, i, a, e, cyc);
        end
    endtask

    always @(posedge clock) cyc++;

    // Model: a byte occupies 8 slots of P cycles; a strobe opens each slot.
    int         P [2] = '{2, 1};
    logic [7:0] mbuf [2], cur [2];
    bit         mbv [2], act [2], mdn [2], mdo [2];
    int         t [2];

    always @(posedge clock or posedge reset) begin
        bit be, st, acc;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mbv[i] = 0; act[i] = 0; t[i] = 0; mdn[i] = 0; mdo[i] = 0;
                mbuf[i] = 8'd0; cur[i] = 8'd0;
            end else begin
                be  = act[i] && (t[i] == 8 * P[i] - 1);
                st  = (!act[i] || be) && mbv[i] && !hin[i];
                acc = vin[i] && !mbv[i];
                mdn[i] = be;
                if (st) begin
                    cur[i] = mbuf[i]; act[i] = 1; t[i] = 0; mbv[i] = 0;
                end else if (be) begin
                    act[i] = 0;
                end else if (act[i]) begin
                    t[i]++;
                end
                if (acc) begin
                    mbuf[i] = din[i]; mbv[i] = 1;
                end
                if (act[i] && (t[i] % P[i] == 0)) mdo[i] = cur[i][7 - t[i] / P[i]];
            end
        end
    end

    always @(negedge clock) begin
        bit ew;
        for (int i = 0; i < 2; i++) begin
            ew = act[i] && (t[i] % P[i] == 0);
            chk("write_out",  i, 16'(w_o[i]),  16'(ew));
            chk("data_out",   i, 16'(d_o[i]),  16'(mdo[i]));
            chk("done_out",   i, 16'(dn_o[i]), 16'(mdn[i]));
            chk("ready_out",  i, 16'(r_o[i]),  16'(!mbv[i]));
            chk("status_out", i, 16'(s_o[i]),  16'(act[i] || mbv[i]));
        end
    end

    // Receiver: rebuilds bytes from strobes, as a chained deserializer would.
    logic [7:0] rx [2];
    int nb [2], nstb [2];
    logic [7:0] rxq [2][$];
    int firstq [2][$];
    int doneq [2][$];

    always @(negedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rx[i] = 8'd0; nb[i] = 0;
            end else begin
                if (dn_o[i]) begin
                    rxq[i].push_back(rx[i]);
                    doneq[i].push_back(cyc);
                end
                if (w_o[i]) begin
                    if (nb[i] % 8 == 0) firstq[i].push_back(cyc);
                    rx[i] = {rx[i][6:0], d_o[i]};
                    nb[i]++;
                    nstb[i]++;
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear(int i);
        rxq[i].delete(); firstq[i].delete(); doneq[i].delete();
    endtask

    task automatic offer(int i, logic [7:0] b);
        bit got;
        got = 0;
        din[i] = b;
        vin[i] = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            if (r_o[i]) got = 1;
            @(negedge clock);
        end
        vin[i] = 1'b0;
        chk("offer_accepted", i, 16'(got), 16'd1);
    endtask

    task automatic idle_literals(int i);
        chk("idle_write", i, 16'(w_o[i]), 16'd0);
        chk("idle_done",  i, 16'(dn_o[i]), 16'd0);
        chk("idle_ready", i, 16'(r_o[i]), 16'd1);
        chk("idle_status", i, 16'(s_o[i]), 16'd0);
        chk("idle_dout",  i, 16'(d_o[i]), 16'd0);
    endtask

    initial begin
        int rel, ns;
        for (int i = 0; i < 2; i++) begin
            din[i] = 8'd0; vin[i] = 1'b0; hin[i] = 1'b0; nstb[i] = 0;
        end
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        for (int i = 0; i < 2; i++) begin
            idle_literals(i);
            chk("idle_strobes", i, 16'(nstb[i]), 16'd0);
        end

        // GAP=1, single byte
        clear(0);
        offer(0, 8'b10110110);
        wait_cyc(24);
        chk("b6_count", 0, 16'(rxq[0].size()), 16'd1);
        chk("b6_byte", 0, 16'(rxq[0][0]), 16'h00B6);
        chk("b6_done_lat", 0, 16'(doneq[0][0] - firstq[0][0]), 16'd16);

        // two bytes chained, second offered while first shifts
        clear(0);
        offer(0, 8'hA5);
        offer(0, 8'h3C);
        wait_cyc(40);
        chk("pair_count", 0, 16'(rxq[0].size()), 16'd2);
        chk("pair_b0", 0, 16'(rxq[0][0]), 16'h00A5);
        chk("pair_b1", 0, 16'(rxq[0][1]), 16'h003C);
        chk("pair_chain", 0, 16'(firstq[0][1]), 16'(doneq[0][0]));
        chk("pair_period", 0, 16'(doneq[0][1] - doneq[0][0]), 16'd16);

        // hold from idle, release, then hold again mid-byte
        clear(0);
        hin[0] = 1'b1;
        ns = nstb[0];
        offer(0, 8'h5A);
        wait_cyc(5);
        chk("hold_status", 0, 16'(s_o[0]), 16'd1);
        chk("hold_ready", 0, 16'(r_o[0]), 16'd0);
        chk("hold_nostrobe", 0, 16'(nstb[0] - ns), 16'd0);
        hin[0] = 1'b0;
        rel = cyc;
        wait_cyc(4);
        hin[0] = 1'b1;
        wait_cyc(20);
        hin[0] = 1'b0;
        chk("hold_count", 0, 16'(rxq[0].size()), 16'd1);
        chk("hold_byte", 0, 16'(rxq[0][0]), 16'h005A);
        chk("hold_release_lat", 0, 16'(firstq[0][0] - rel), 16'd1);

        // GAP=0 back-to-back bits
        clear(1);
        ns = nstb[1];
        offer(1, 8'hF0);
        wait_cyc(15);
        chk("f0_count", 1, 16'(rxq[1].size()), 16'd1);
        chk("f0_byte", 1, 16'(rxq[1][0]), 16'h00F0);
        chk("f0_done_lat", 1, 16'(doneq[1][0] - firstq[1][0]), 16'd8);
        chk("f0_strobes", 1, 16'(nstb[1] - ns), 16'd8);

        // reset mid-byte with a second byte buffered
        clear(0);
        offer(0, 8'hFF);
        offer(0, 8'h11);
        wait_cyc(4);
        #2 reset = 1'b1;
        #1 idle_literals(0);
        @(negedge clock);
        reset = 1'b0;
        wait_cyc(20);
        chk("rst_nodone", 0, 16'(doneq[0].size()), 16'd0);
        chk("rst_ready", 0, 16'(r_o[0]), 16'd1);
        clear(0);
        offer(0, 8'h81);
        wait_cyc(24);
        chk("post_rst_count", 0, 16'(rxq[0].size()), 16'd1);
        chk("post_rst_byte", 0, 16'(rxq[0][0]), 16'h0081);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
